debug_unit: RTL and testbench

//  Device-side end of the host debug link: decodes UART command bytes from the host and replies.

---
 rtl/debug_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_debug_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host debug link endpoint: decodes UART command bytes, loads instruction memory,
// controls run/step mode, dumps registers and pipeline latches, and acknowledges with 'R'.
module debug_unit #(
  parameter int SIZE            = 32,
  parameter int IF_ID_SIZE      = 32,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 77,
  parameter int MEM_WB_SIZE     = 71,
  parameter int MAX_INSTRUCTION = 64,
  parameter int NUM_REGISTERS   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  input  logic [IF_ID_SIZE-1:0]  i_if_id,
  input  logic [ID_EX_SIZE-1:0]  i_id_ex,
  input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
  input  logic                   i_halt,
  output logic [4:0]             o_reg_addr,
  input  logic [SIZE-1:0]        i_reg_data,
  output logic [SIZE-1:0]        o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  output logic                   o_imem_we,
  output logic                   o_stall,
  output logic                   o_pc_reset
);

  localparam int DUMP_W = 136;
  localparam logic [7:0] IF_ID_BYTES  = 8'((IF_ID_SIZE + 7) / 8);
  localparam logic [7:0] ID_EX_BYTES  = 8'((ID_EX_SIZE + 7) / 8);
  localparam logic [7:0] EX_MEM_BYTES = 8'((EX_MEM_SIZE + 7) / 8);
  localparam logic [7:0] MEM_WB_BYTES = 8'((MEM_WB_SIZE + 7) / 8);
  localparam logic [7:0] REG_BYTES    = 8'(NUM_REGISTERS * 4);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, DUMP_LOAD, TX_START, TX_WAIT, ACK
  } state_t;

  state_t            state_q, state_d;
  logic              step_mode_q, step_mode_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              last_q, last_d;
  logic              dump_regs_q, dump_regs_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DUMP_W-1:0] shift_q, shift_d;
  logic [4:0]        reg_addr_q, reg_addr_d;
  logic [7:0]        ld_n_q, ld_n_d;
  logic [7:0]        ld_k_q, ld_k_d;
  logic [1:0]        ld_idx_q, ld_idx_d;
  logic [SIZE-1:0]   ld_word_q, ld_word_d;
  logic              pc_reset_q, pc_reset_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      step_mode_q <= 1'b1;
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      dump_regs_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      reg_addr_q  <= '0;
      ld_n_q      <= '0;
      ld_k_q      <= '0;
      ld_idx_q    <= '0;
      ld_word_q   <= '0;
      pc_reset_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      dump_regs_q <= dump_regs_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      ld_n_q      <= ld_n_d;
      ld_k_q      <= ld_k_d;
      ld_idx_q    <= ld_idx_d;
      ld_word_q   <= ld_word_d;
      pc_reset_q  <= pc_reset_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    dump_regs_d = dump_regs_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    ld_n_d      = ld_n_q;
    ld_k_d      = ld_k_q;
    ld_idx_d    = ld_idx_q;
    ld_word_d   = ld_word_q;
    pc_reset_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          last_d      = 1'b0;
          dump_regs_d = 1'b0;
          // Latches are snapshotted here so a dump is coherent while the pipeline moves.
          unique case (i_rx_data)
            8'h01: begin
              dump_regs_d = 1'b1;
              reg_addr_d  = '0;
              cnt_d       = REG_BYTES;
              state_d     = DUMP_LOAD;
            end
            8'h02: begin
              shift_d                   = '0;
              shift_d[IF_ID_SIZE-1:0]   = i_if_id;
              tx_data_d                 = i_if_id[7:0];
              cnt_d                     = IF_ID_BYTES;
              state_d                   = TX_START;
            end
            8'h03: begin
              shift_d                   = '0;
              shift_d[ID_EX_SIZE-1:0]   = i_id_ex;
              tx_data_d                 = i_id_ex[7:0];
              cnt_d                     = ID_EX_BYTES;
              state_d                   = TX_START;
            end
            8'h04: begin
              shift_d                   = '0;
              shift_d[EX_MEM_SIZE-1:0]  = i_ex_mem;
              tx_data_d                 = i_ex_mem[7:0];
              cnt_d                     = EX_MEM_BYTES;
              state_d                   = TX_START;
            end
            8'h05: begin
              shift_d                   = '0;
              shift_d[MEM_WB_SIZE-1:0]  = i_mem_wb;
              tx_data_d                 = i_mem_wb[7:0];
              cnt_d                     = MEM_WB_BYTES;
              state_d                   = TX_START;
            end
            8'h07: state_d = LD_CNT;
            8'h08: begin
              step_mode_d = 1'b0;
              state_d     = RUN;
            end
            8'h09: begin
              step_mode_d = 1'b1;
              state_d     = ACK;
            end
            8'h0A: state_d = step_mode_q ? STEP : ACK;
            8'h0D: begin
              pc_reset_d = 1'b1;
              state_d    = ACK;
            end
            default: begin
              tx_data_d = 8'h45;
              last_d    = 1'b1;
              state_d   = TX_START;
            end
          endcase
        end
      end
      LD_CNT: begin
        if (i_rx_valid) begin
          ld_n_d   = i_rx_data;
          ld_k_d   = '0;
          ld_idx_d = '0;
          if (i_rx_data == 8'd0) begin
            pc_reset_d = 1'b1;
            state_d    = ACK;
          end else begin
            state_d = LD_BYTE;
          end
        end
      end
      LD_BYTE: begin
        if (i_rx_valid) begin
          ld_word_d = {i_rx_data, ld_word_q[SIZE-1:8]};
          ld_idx_d  = ld_idx_q + 2'd1;
          if (ld_idx_q == 2'd3) state_d = LD_WR;
        end
      end
      LD_WR: begin
        ld_k_d = ld_k_q + 8'd1;
        if (ld_k_q + 8'd1 == ld_n_q) begin
          pc_reset_d = 1'b1;
          state_d    = ACK;
        end else begin
          state_d = LD_BYTE;
        end
      end
      RUN:  if (i_halt) state_d = ACK;
      STEP: state_d = ACK;
      DUMP_LOAD: begin
        shift_d             = '0;
        shift_d[SIZE-1:0]   = i_reg_data;
        tx_data_d           = i_reg_data[7:0];
        state_d             = TX_START;
      end
      ACK: begin
        tx_data_d = 8'h52;
        last_d    = 1'b1;
        state_d   = TX_START;
      end
      TX_START: state_d = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            // cnt_q counts bytes still owed including the one just sent.
            cnt_d   = cnt_q - 8'd1;
            shift_d = shift_q >> 8;
            if (cnt_q == 8'd1) begin
              state_d = ACK;
            end else if (dump_regs_q && cnt_q[1:0] == 2'd1) begin
              reg_addr_d = reg_addr_q + 5'd1;
              state_d    = DUMP_LOAD;
            end else begin
              tx_data_d = shift_q[15:8];
              state_d   = TX_START;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = (state_q == TX_START);
  assign o_stall     = !((state_q == RUN) || (state_q == STEP));
  assign o_imem_we   = (state_q == LD_WR) && (int'(ld_k_q) < MAX_INSTRUCTION);
  assign o_imem_addr = SIZE'({ld_k_q, 2'b00});
  assign o_imem_data = ld_word_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_pc_reset  = pc_reset_q;

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: UART/imem/regfile models around the DUT, a command table,
// directed corner sequences and a randomized command stream against a reference model.
module tb_debug_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_done = 1'b0;
  logic [31:0]  if_id;
  logic [128:0] id_ex;
  logic [76:0]  ex_mem;
  logic [70:0]  mem_wb;
  logic         halt;
  logic [4:0]   reg_addr;
  logic [31:0]  reg_data;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_data;
  logic         imem_we;
  logic         stall;
  logic         pc_reset;

  logic [31:0]  regs [32];
  assign reg_data = regs[reg_addr];

  debug_unit #(
    .SIZE(32), .IF_ID_SIZE(32), .ID_EX_SIZE(129), .EX_MEM_SIZE(77),
    .MEM_WB_SIZE(71), .MAX_INSTRUCTION(64), .NUM_REGISTERS(32)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .i_if_id(if_id), .i_id_ex(id_ex), .i_ex_mem(ex_mem), .i_mem_wb(mem_wb),
    .i_halt(halt), .o_reg_addr(reg_addr), .i_reg_data(reg_data),
    .o_imem_addr(imem_addr), .o_imem_data(imem_data), .o_imem_we(imem_we),
    .o_stall(stall), .o_pc_reset(pc_reset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  txq [$];
  logic [63:0] wq [$];
  logic [7:0]  exp_tx [$];
  logic [63:0] exp_wr [$];
  logic [31:0] ld_words [$];
  int pcr_cnt, pcr_at_tx, unstall;
  bit busy = 1'b0;
  int dly = 0;
  logic [7:0] held = '0;
  bit mstep = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Host-side UART and observation of imem / pc_reset / stall.
  always @(negedge clk) begin
    if (rst) begin
      tx_done = 1'b0;
      busy = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (imem_we) wq.push_back({imem_addr, imem_data});
      if (pc_reset) begin
        pcr_cnt++;
        pcr_at_tx = txq.size();
      end
      if (!stall) unstall++;
      if (busy) begin
        if (dly == 0) begin
          chk("tx_hold", 64'(tx_data), 64'(held));
          tx_done = 1'b1;
          busy = 1'b0;
        end else begin
          dly--;
        end
      end
      if (tx_start) begin
        chk("tx_overlap", 64'(busy), 64'd0);
        txq.push_back(tx_data);
        held = tx_data;
        busy = 1'b1;
        dly = $urandom_range(0, 3);
      end
    end
  end

  task automatic clear_obs();
    txq.delete();
    wq.delete();
    exp_tx.delete();
    exp_wr.delete();
    pcr_cnt = 0;
    pcr_at_tx = -1;
    unstall = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while ((txq.size() < n || busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      checks++;
      failures++;
      $display("FAIL tx_timeout actual=%0d expected=%0d", txq.size(), n);
    end
    repeat (6) @(negedge clk);
  endtask

  function automatic bit is_cmd(input logic [7:0] b);
    return (b >= 8'h01 && b <= 8'h05) || b == 8'h07 || b == 8'h08 ||
           b == 8'h09 || b == 8'h0A || b == 8'h0D;
  endfunction

  task automatic push_bytes(input logic [135:0] v, input int nb);
    for (int i = 0; i < nb; i++) exp_tx.push_back(v[8*i +: 8]);
  endtask

  task automatic compare_tx(input string name);
    chk({name, "_count"}, 64'(txq.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
      chk({name, "_byte"}, 64'(txq[i]), 64'(exp_tx[i]));
  endtask

  // Single-byte commands other than load and run.
  task automatic run_cmd(input logic [7:0] cmd);
    int exp_un, exp_pcr;
    clear_obs();
    exp_un = 0;
    exp_pcr = 0;
    case (cmd)
      8'h01: for (int r = 0; r < 32; r++) push_bytes(136'(regs[r]), 4);
      8'h02: push_bytes(136'(if_id), 4);
      8'h03: push_bytes(136'(id_ex), 17);
      8'h04: push_bytes(136'(ex_mem), 10);
      8'h05: push_bytes(136'(mem_wb), 9);
      8'h09: mstep = 1'b1;
      8'h0A: exp_un = mstep ? 1 : 0;
      8'h0D: exp_pcr = 1;
      default: ;
    endcase
    exp_tx.push_back(is_cmd(cmd) ? 8'h52 : 8'h45);
    send(cmd);
    wait_tx(exp_tx.size());
    compare_tx("cmd");
    chk("cmd_unstall", 64'(unstall), 64'(exp_un));
    chk("cmd_pcreset", 64'(pcr_cnt), 64'(exp_pcr));
    chk("cmd_nowrite", 64'(wq.size()), 64'd0);
  endtask

  task automatic do_load(input int n, input bit fixed);
    logic [31:0] w;
    clear_obs();
    if (!fixed) begin
      ld_words.delete();
      for (int k = 0; k < n; k++) ld_words.push_back($urandom());
    end
    for (int k = 0; k < n; k++)
      if (k < 64) exp_wr.push_back({32'(4 * k), ld_words[k]});
    send(8'h07);
    send(8'(n));
    for (int k = 0; k < n; k++) begin
      w = ld_words[k];
      for (int b = 0; b < 4; b++) send(w[8*b +: 8]);
    end
    wait_tx(1);
    chk("ld_nwrites", 64'(wq.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wq.size(); i++)
      chk("ld_write", wq[i], exp_wr[i]);
    chk("ld_tx_count", 64'(txq.size()), 64'd1);
    if (txq.size() > 0) chk("ld_ack", 64'(txq[0]), 64'h52);
    chk("ld_pcreset", 64'(pcr_cnt), 64'd1);
    chk("ld_pcr_before_ack", 64'(pcr_at_tx), 64'd0);
    chk("ld_stalled", 64'(unstall), 64'd0);
  endtask

  task automatic do_run(input int d);
    clear_obs();
    mstep = 1'b0;
    send(8'h08);
    repeat (d) @(negedge clk);
    chk("run_stall_low", 64'(stall), 64'd0);
    send(8'h09);
    chk("run_ignores_bytes", 64'(txq.size()), 64'd0);
    chk("run_still_running", 64'(stall), 64'd0);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    wait_tx(1);
    chk("run_tx_count", 64'(txq.size()), 64'd1);
    if (txq.size() > 0) chk("run_ack", 64'(txq[0]), 64'h52);
    chk("run_stall_high", 64'(stall), 64'd1);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         nbytes;
    logic [7:0] last;
    int         unst;
    int         pcr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [7:0] b;
    logic [128:0] idex_ref;
    int op;

    tbl[0]  = '{8'h09, 1,   8'h52, 0, 0};
    tbl[1]  = '{8'h0A, 1,   8'h52, 1, 0};
    tbl[2]  = '{8'h0D, 1,   8'h52, 0, 1};
    tbl[3]  = '{8'h55, 1,   8'h45, 0, 0};
    tbl[4]  = '{8'h00, 1,   8'h45, 0, 0};
    tbl[5]  = '{8'hFF, 1,   8'h45, 0, 0};
    tbl[6]  = '{8'h06, 1,   8'h45, 0, 0};
    tbl[7]  = '{8'h02, 5,   8'h52, 0, 0};
    tbl[8]  = '{8'h03, 18,  8'h52, 0, 0};
    tbl[9]  = '{8'h04, 11,  8'h52, 0, 0};
    tbl[10] = '{8'h05, 10,  8'h52, 0, 0};
    tbl[11] = '{8'h01, 129, 8'h52, 0, 0};
    tbl[12] = '{8'h0A, 1,   8'h52, 1, 0};

    rst = 1'b1;
    rx_data = '0;
    rx_valid = 1'b0;
    halt = 1'b0;
    if_id = $urandom();
    id_ex = 129'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    ex_mem = 77'({$urandom(), $urandom(), $urandom()});
    mem_wb = 71'({$urandom(), $urandom(), $urandom()});
    for (int r = 0; r < 32; r++) regs[r] = $urandom();
    repeat (3) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd1);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_pc_reset", 64'(pc_reset), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_imem_data", 64'(imem_data), 64'd0);
    chk("rst_reg_addr", 64'(reg_addr), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Command table
    for (int i = 0; i < 13; i++) begin
      clear_obs();
      send(tbl[i].cmd);
      wait_tx(tbl[i].nbytes);
      chk("tbl_count", 64'(txq.size()), 64'(tbl[i].nbytes));
      if (txq.size() > 0) chk("tbl_last", 64'(txq[txq.size()-1]), 64'(tbl[i].last));
      chk("tbl_unstall", 64'(unstall), 64'(tbl[i].unst));
      chk("tbl_pcreset", 64'(pcr_cnt), 64'(tbl[i].pcr));
    end

    // Two-word load
    ld_words.delete();
    ld_words.push_back(32'h3C010000);
    ld_words.push_back(32'h3C020001);
    do_load(2, 1'b1);
    do_load(0, 1'b0);

    // ID/EX snapshot held while the latch changes mid-dump
    idex_ref = 129'h1_0123456789ABCDEF_0123456789ABCDEF;
    id_ex = idex_ref;
    clear_obs();
    push_bytes(136'(idex_ref), 17);
    exp_tx.push_back(8'h52);
    send(8'h03);
    id_ex = 129'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    wait_tx(18);
    compare_tx("idex");
    if (txq.size() > 16) chk("idex_top", 64'(txq[16]), 64'h01);

    // Run until halt, then step commands in both modes
    do_run(5);
    run_cmd(8'h0A);
    run_cmd(8'h09);
    run_cmd(8'h0A);

    // Register dump with a recognisable pattern
    for (int r = 0; r < 32; r++) regs[r] = 32'(r) * 32'h01010101;
    run_cmd(8'h01);
    run_cmd(8'h55);

    // Word index past the end of instruction memory
    do_load(65, 1'b0);

    // Reset in the middle of a load word
    clear_obs();
    send(8'h07);
    send(8'h01);
    send(8'h3C);
    send(8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_nowrite", 64'(wq.size()), 64'd0);
    chk("abort_stall", 64'(stall), 64'd1);
    chk("abort_no_pcreset", 64'(pcr_cnt), 64'd0);
    chk("abort_no_tx", 64'(txq.size()), 64'd0);
    chk("abort_imem_we", 64'(imem_we), 64'd0);
    rst = 1'b0;
    mstep = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(8'h09);
    do_load(1, 1'b0);

    // Randomized command stream
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 10);
      case (op)
        0: begin
          for (int r = 0; r < 32; r++) regs[r] = $urandom();
          run_cmd(8'h01);
        end
        1: begin if_id = $urandom(); run_cmd(8'h02); end
        2: begin
          id_ex = 129'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
          run_cmd(8'h03);
        end
        3: begin ex_mem = 77'({$urandom(), $urandom(), $urandom()}); run_cmd(8'h04); end
        4: begin mem_wb = 71'({$urandom(), $urandom(), $urandom()}); run_cmd(8'h05); end
        5: do_load($urandom_range(0, 4), 1'b0);
        6: do_run($urandom_range(1, 8));
        7: run_cmd(8'h09);
        8: run_cmd(8'h0A);
        9: run_cmd(8'h0D);
        default: begin
          b = 8'($urandom_range(0, 255));
          while (is_cmd(b)) b = 8'($urandom_range(0, 255));
          run_cmd(b);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
